gray_step_checker: RTL and testbench
====================================

// Module: gray_step_checker
// PURPOSE
//  Consumes a free-running W-bit Gray-code count (from the Gray counter stage) and
//  decodes it to binary. Checks that every change is exactly +1 mod 2^W.
//  Tracks lock and error status with a small FSM.
//  Feeds downstream logic that needs a trusted binary position or count.
// PARAMETERS
//  W         4  Gray/binary width
//  LOCK_CNT  3  consecutive good steps required to enter LOCK (>=1)
//  ERR_W     8  error counter width
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous, active-low reset
//  gray_i     in   W      Gray-coded count from upstream
//  clr_i      in   1      sync clear: err_cnt_o<=0, FSM->ACQ
//  bin_o      out  W      decoded binary of latest captured sample
//  bin_vld_o  out  1      1-cycle pulse: bin_o updated with a good step while in LOCK
//  locked_o   out  1      1 while FSM in LOCK
//  err_o      out  1      1-cycle pulse on a bad step detected in LOCK
//  err_cnt_o  out  ERR_W  saturating count of err_o pulses
// BEHAVIOUR
//  - Reset (async): all outputs 0. FSM=ACQ, good counter=0, first flag set.
//  - Capture: gray_q<=gray_i each cycle (stage 1).
//  - Decode: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i]. Register decode into bin_o (stage 2).
//  - Latency gray_i->bin_o: 2 clk without macro, 4 clk with it.
//  - Step evaluation compares the new bin against the previous bin_o:
//    * equal           -> hold. Legal upstream stall. No pulse, no count change.
//    * new==prev+1 mod 2^W -> good. 2^W-1 -> 0 is good.
//    * otherwise       -> bad. Includes backwards and multi-bit jumps.
//  - The first sample after reset or clr_i loads bin_o and is not evaluated.
//  - FSM ACQ: good -> goodcnt++; bad -> goodcnt=0.
//    goodcnt reaching LOCK_CNT -> LOCK next cycle.
//  - FSM LOCK: good -> bin_vld_o=1. Bad -> err_o=1, err_cnt_o++ (saturate at all-ones), ->FAULT.
//  - FSM FAULT: exactly 1 cycle, outputs idle. ->ACQ with goodcnt=0.
//    A step arriving during FAULT is treated as the first sample and is not evaluated.
//  - Bad steps in ACQ/FAULT never raise err_o.
//  - locked_o, bin_vld_o and err_o are registered, aligned with the bin_o update.
//  - clr_i has priority over a simultaneous error:
//    err_cnt_o=0, no increment, FSM->ACQ, first flag set. err_o is still suppressed.
//  - Reset mid-operation clears immediately (async). Pipeline contents are discarded.
// CONFIGURATION
//  GRAY_STEP_CHECKER_SYNC_EN defined:
//    gray_i passes a 2-flop synchronizer (reset 0) before the capture stage.
//    Use when the upstream is in another clock domain. Latency = 4 clk.
//  Undefined: no synchronizer; gray_i must be synchronous to clk. Latency = 2 clk.
// TESTING (W=4, LOCK_CNT=3 unless noted)
//  1. Reset, drive Gray seq 0000,0001,0011,0010,0110 one per clk
//     -> bin_o 0,1,2,3,4; locked_o=1 after the 3rd good step;
//        bin_vld_o pulses on the 4th; err_cnt_o=0.
//  2. Locked, drive 1000 (15) then 0000 (0)
//     -> wrap accepted; bin_o=0; bin_vld_o=1; err_o=0.
//  3. Locked at 0011 (2), drive 0100 (7)
//     -> err_o 1 cycle, err_cnt_o=1, locked_o=0, FAULT 1 cycle;
//        relock after 3 further good steps.
//  4. Locked, hold gray_i at 0111 for 10 clk
//     -> no bin_vld_o, no err_o, locked_o stays 1.
//  5. ERR_W=2, force 5 lock/bad cycles -> err_cnt_o saturates at 3.
//     Then clr_i together with a bad step -> err_cnt_o=0, err_o=0, FSM ACQ.
//  6. Assert rst_n=0 mid-LOCK between clk edges
//     -> all outputs 0 immediately; resume from scenario 1.
//     Repeat 1 and 3 with GRAY_STEP_CHECKER_SYNC_EN and check 4-clk latency.

Source files
------------

// File: rtl/gray_step_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_step_checker_if : Gray count in, decoded binary and status out      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface gray_step_checker_if #(
  parameter int W     = 4,
  parameter int ERR_W = 8
);
  logic [W-1:0]     gray_i;
  logic             clr_i;
  logic [W-1:0]     bin_o;
  logic             bin_vld_o;
  logic             locked_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;

  modport master (
    output gray_i, clr_i,
    input  bin_o, bin_vld_o, locked_o, err_o, err_cnt_o
  );

  modport slave (
    input  gray_i, clr_i,
    output bin_o, bin_vld_o, locked_o, err_o, err_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/gray_step_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_step_checker : Gray->binary decode, +1 step check, ACQ/LOCK/FAULT   |
// | GRAY_STEP_CHECKER_SYNC_EN adds a 2-flop input synchronizer. Rev 1.0      |
// +--------------------------------------------------------------------------+
module gray_step_checker #(
  parameter int W        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  gray_step_checker_if.slave bus
);
  localparam int GC_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_t;

  logic [W-1:0] gray_src;

`ifdef GRAY_STEP_CHECKER_SYNC_EN
  localparam int VD = 3;
  logic [W-1:0] sync1;
  logic [W-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.gray_i;
      sync2 <= sync1;
    end
  end

  assign gray_src = sync2;
`else
  localparam int VD = 1;
  assign gray_src = bus.gray_i;
`endif

  // vld_sr marks which pipeline stages hold a sample taken after reset
  logic [W-1:0]  gray_q;
  logic [VD-1:0] vld_sr;
  logic          s_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
      vld_sr <= '0;
    end else begin
      gray_q <= gray_src;
      vld_sr <= (vld_sr << 1) | VD'(1);
    end
  end

  assign s_vld = vld_sr[VD-1];

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t           state, state_nxt;
  logic [GC_W-1:0]  gc, gc_nxt;
  logic             first, first_nxt;
  logic [W-1:0]     bin_q, bin_nxt;
  logic             vld_q, vld_nxt;
  logic             err_q, err_nxt;
  logic [ERR_W-1:0] cnt_q, cnt_nxt;

  logic [W-1:0] new_bin;
  logic         is_same;
  logic         is_good;

  assign new_bin = g2b(gray_q);
  assign is_same = (new_bin == bin_q);
  assign is_good = (new_bin == bin_q + W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACQ;
      gc    <= '0;
      first <= 1'b1;
      bin_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      gc    <= gc_nxt;
      first <= first_nxt;
      bin_q <= bin_nxt;
      vld_q <= vld_nxt;
      err_q <= err_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gc_nxt    = gc;
    first_nxt = first;
    bin_nxt   = bin_q;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    cnt_nxt   = cnt_q;

    if (s_vld) begin
      bin_nxt = new_bin;
      // The sample taken during FAULT re-seeds the reference like a first sample
      if (first || state == FAULT) begin
        first_nxt = 1'b0;
        state_nxt = ACQ;
        gc_nxt    = '0;
      end else if (!is_same) begin
        case (state)
          ACQ: begin
            if (!is_good) begin
              gc_nxt = '0;
            end else if (gc == GC_W'(LOCK_CNT - 1)) begin
              gc_nxt    = '0;
              state_nxt = LOCK;
            end else begin
              gc_nxt = gc + GC_W'(1);
            end
          end
          LOCK: begin
            if (is_good) begin
              vld_nxt = 1'b1;
            end else begin
              err_nxt   = 1'b1;
              cnt_nxt   = (cnt_q == '1) ? cnt_q : cnt_q + ERR_W'(1);
              gc_nxt    = '0;
              state_nxt = FAULT;
            end
          end
          default: state_nxt = ACQ;
        endcase
      end
    end

    // clr_i wins over any step result evaluated in the same cycle
    if (bus.clr_i) begin
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
      vld_nxt   = 1'b0;
      gc_nxt    = '0;
      first_nxt = 1'b1;
      state_nxt = ACQ;
    end
  end

  assign bus.bin_o     = bin_q;
  assign bus.bin_vld_o = vld_q;
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = cnt_q;
  assign bus.locked_o  = (state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_gray_step_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gray_step_checker : directed scenarios plus random Gray walk vs model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gray_step_checker;
  localparam int W        = 4;
  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 2;
  localparam int MASK     = (1 << W) - 1;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;
`ifdef GRAY_STEP_CHECKER_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  localparam int M_ACQ = 0, M_LOCKED = 1, M_FAULT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gray_step_checker_if #(.W(W), .ERR_W(ERR_W)) bus ();

  gray_step_checker #(.W(W), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain integers, samples delayed through a queue
  int pipe[$];
  int m_bin, m_cnt, m_run, m_mode, m_first;
  int m_vld, m_err;
  int cur_b;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int to_bin(input int g);
    int b = g;
    for (int s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  task automatic model_reset();
    pipe.delete();
    m_bin = 0; m_cnt = 0; m_run = 0; m_mode = M_ACQ; m_first = 1;
    m_vld = 0; m_err = 0;
  endtask

  task automatic model_edge(input int g, input int c);
    pipe.push_back(g);
    m_vld = 0;
    m_err = 0;
    if (pipe.size() > LAT - 1) begin
      int nb;
      int diff;
      nb   = to_bin(pipe.pop_front());
      diff = (nb - m_bin) & MASK;
      if (m_first != 0 || m_mode == M_FAULT) begin
        m_first = 0;
        m_mode  = M_ACQ;
        m_run   = 0;
      end else if (diff == 1) begin
        if (m_mode == M_LOCKED) m_vld = 1;
        else begin
          m_run++;
          if (m_run >= LOCK_CNT) m_mode = M_LOCKED;
        end
      end else if (diff != 0) begin
        if (m_mode == M_LOCKED) begin
          m_err  = 1;
          m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
          m_mode = M_FAULT;
        end else begin
          m_run = 0;
        end
      end
      m_bin = nb;
    end
    if (c != 0) begin
      m_cnt = 0; m_mode = M_ACQ; m_run = 0; m_first = 1; m_vld = 0; m_err = 0;
    end
  endtask

  task automatic compare_all();
    check_val("bin_o",     int'(bus.bin_o),     m_bin);
    check_val("bin_vld_o", int'(bus.bin_vld_o), m_vld);
    check_val("err_o",     int'(bus.err_o),     m_err);
    check_val("locked_o",  int'(bus.locked_o),  (m_mode == M_LOCKED) ? 1 : 0);
    check_val("err_cnt_o", int'(bus.err_cnt_o), m_cnt);
  endtask

  // Drive binary value b as Gray for one clock, then compare at the negedge
  task automatic step(input int b, input int c);
    bus.gray_i = W'(to_gray(b & MASK));
    bus.clr_i  = (c != 0);
    cur_b      = b & MASK;
    @(posedge clk);
    model_edge(to_gray(b & MASK), c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++) step(cur_b, 0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.gray_i = '0;
    bus.clr_i  = 1'b0;
    cur_b      = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Count 0..4 from reset: lock after third good step, pulse on fourth
    for (int b = 0; b <= 4; b++) step(b, 0);
    flush();
    check_val("s1_locked", int'(bus.locked_o), 1);
    check_val("s1_bin", int'(bus.bin_o), 4);
    check_val("s1_cnt", int'(bus.err_cnt_o), 0);

    // Count up through the 15 -> 0 wrap
    for (int b = 5; b <= 16; b++) step(b, 0);
    flush();
    check_val("s2_bin_wrap", int'(bus.bin_o), 0);
    check_val("s2_locked", int'(bus.locked_o), 1);

    // Jump 2 -> 7 while locked, then relock
    step(1, 0);
    step(2, 0);
    step(7, 0);
    for (int b = 8; b <= 11; b++) step(b, 0);
    flush();
    check_val("s3_cnt", int'(bus.err_cnt_o), 1);
    check_val("s3_relock", int'(bus.locked_o), 1);

    // Stall at Gray 0111 (binary 5) for 10 clocks
    step(12, 0); step(13, 0); step(14, 0); step(15, 0);
    step(0, 0);  step(1, 0);  step(2, 0);  step(3, 0);  step(4, 0); step(5, 0);
    for (int i = 0; i < 10; i++) step(5, 0);
    check_val("s4_locked", int'(bus.locked_o), 1);

    // Five lock/bad cycles saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      int base;
      base = (cur_b + 5) & MASK;
      step(base, 0);
      for (int j = 1; j <= 4; j++) step(base + j, 0);
    end
    flush();
    check_val("s5_sat", int'(bus.err_cnt_o), CNT_MAX);
    check_val("s5_locked", int'(bus.locked_o), 1);

    // clr_i lands on the edge that evaluates a bad step
    begin
      int bad;
      bad = (cur_b + 6) & MASK;
      step(bad, 0);
      for (int i = 0; i < LAT - 2; i++) step(bad, 0);
      step(bad, 1);
      check_val("s5_clr_err", int'(bus.err_o), 0);
      check_val("s5_clr_cnt", int'(bus.err_cnt_o), 0);
      check_val("s5_clr_lock", int'(bus.locked_o), 0);
    end

    // Lock again, then pull reset between edges
    for (int j = 1; j <= 6; j++) step(cur_b + 1, 0);
    check_val("s6_prelock", int'(bus.locked_o), 1);
    async_reset();
    cur_b = 0;
    for (int b = 0; b <= 4; b++) step(b, 0);
    flush();
    check_val("s6_relock", int'(bus.locked_o), 1);

    // Random walk: stalls, +1 steps, arbitrary jumps, sporadic clears
    for (int n = 0; n < 600; n++) begin
      int r;
      int b;
      r = int'($urandom_range(0, 99));
      if (r < 20)      b = cur_b;
      else if (r < 85) b = (cur_b + 1) & MASK;
      else             b = int'($urandom_range(0, MASK));
      step(b, ($urandom_range(0, 99) < 3) ? 1 : 0);
      if (n == 300) begin
        async_reset();
        cur_b = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
